mips_fetch_unit: RTL
====================

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 IorD  in  1  memory address select from control unit (0 = pc, 1 = alu_out).
REQ-005 IRWrite  in  1  instruction register load enable.
REQ-006 PCWrite  in  1  unconditional PC write enable.
REQ-007 Branch  in  1  conditional PC write enable, qualified by alu_zero.
REQ-008 PCSrc  in  2  next-PC select.
REQ-009 alu_result  in  32  current-cycle ALU output.
REQ-010 alu_zero  in  1  ALU zero flag.
REQ-011 mem_rdata  in  32  combinational read data of unified instruction/data memory at mem_addr.
REQ-012 mem_addr  out  32  memory address.
REQ-013 pc  out  32  program counter register.
REQ-014 instr  out  32  instruction register.
REQ-015 op  out  mips_op_e  instr[31:26], to control unit.
REQ-016 funct  out  mips_funct_e  instr[5:0], to control unit.
REQ-017 rs, rt, rd  out  5 each  instr[25:21], instr[20:16], instr[15:11].
REQ-018 imm_sext  out  32  instr[15:0] sign-extended.
REQ-019 mdr  out  32  memory data register.
REQ-020 alu_out  out  32  ALU output register.
REQ-021 instr_count  out  32  retired-fetch counter.
REQ-022 pc_misalign  out  1  sticky misaligned-PC flag.

Function
REQ-023 pc_en = PCWrite | (Branch & alu_zero); pc loads next_pc on a rising edge with pc_en=1, else holds.
REQ-024 next_pc: PCSrc 00 -> alu_result; 01 -> alu_out; 10 -> {pc[31:28], instr[25:0], 2'b00}; 11 -> pc (hold, no error).
REQ-025 mem_addr = IorD ? alu_out : pc, purely combinational, zero latency.
REQ-026 instr loads mem_rdata when IRWrite=1, else holds; op/funct/rs/rt/rd/imm_sext are combinational decodes of instr.
REQ-027 mdr loads mem_rdata and alu_out loads alu_result every cycle, unconditionally (one-cycle latency).
REQ-028 IRWrite and PCWrite in the same cycle: instr captures mem_rdata addressed by the old pc; pc takes next_pc; both updates on the same edge.
REQ-029 Branch=1, alu_zero=0, PCWrite=0: pc holds.
REQ-030 instr_count increments by 1 on each edge with IRWrite=1; 32'hFFFF_FFFF wraps to 0.
REQ-031 pc_misalign sets on an edge where pc_en=1 and next_pc[1:0]!=2'b00; pc still loads the value unmodified; the flag is cleared only by reset.
REQ-032 Jump target uses pc[31:28] of the already-incremented pc (pc+4 from fetch).

Reset
REQ-033 rst_n=0 asynchronously forces pc=RESET_PC, instr=0, mdr=0, alu_out=0, instr_count=0, pc_misalign=0, independent of clk.
REQ-034 Reset asserted mid-instruction discards all partial state; the first edge after deassertion behaves as a normal fetch edge.

Structure
REQ-035 mips_op_e and mips_funct_e are taken from MIPS_pkg; the instruction field bit positions and the sign-extension width are defined as constants in MIPS_pkg.
REQ-036 RESET_PC remains a module parameter and is not a package constant.
REQ-037 A single sub-module mips_pc_reg holds the PC register, the next-PC mux, and the misalign flag; all other logic is inline.

Verification
REQ-038 Reset, then IRWrite=1, PCWrite=1, PCSrc=00, alu_result=4, mem_rdata=32'h2008_0005 -> instr=32'h2008_0005, op=ADDI, rt=8, imm_sext=5, pc=4, instr_count=1.
REQ-039 Branch=1, alu_zero=1, PCSrc=01, alu_out=32'h40 -> pc=32'h40; repeat with alu_zero=0 -> pc unchanged.
REQ-040 pc=32'h1000_0008, instr=32'h0800_0010, PCSrc=10, PCWrite=1 -> pc=32'h1000_0040.
REQ-041 IorD=1, alu_out=32'h80 -> mem_addr=32'h80 in the same cycle; mdr equals mem_rdata one edge later.
REQ-042 PCWrite=1, alu_result=32'h6 -> pc=6, pc_misalign=1; pc_misalign stays 1 across later aligned writes until rst_n=0.
REQ-043 instr_count preloaded to 32'hFFFF_FFFF, one IRWrite edge -> 0; rst_n pulsed low between edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/MIPS_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, instruction field positions
// and the small helpers the multicycle datapath blocks use to slice instructions.
package MIPS_pkg;

  localparam int XLEN = 32;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int IMM_W       = 16;
  localparam int JIDX_W      = 26;
  localparam int PC_REGION_W = 4;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'd0,
    OP_J     = 6'd2,
    OP_JAL   = 6'd3,
    OP_BEQ   = 6'd4,
    OP_BNE   = 6'd5,
    OP_ADDI  = 6'd8,
    OP_ADDIU = 6'd9,
    OP_SLTI  = 6'd10,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_LUI   = 6'd15,
    OP_LW    = 6'd35,
    OP_SW    = 6'd43
  } mips_op_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'd0,
    FN_SRL  = 6'd2,
    FN_JR   = 6'd8,
    FN_ADD  = 6'd32,
    FN_ADDU = 6'd33,
    FN_SUB  = 6'd34,
    FN_SUBU = 6'd35,
    FN_AND  = 6'd36,
    FN_OR   = 6'd37,
    FN_XOR  = 6'd38,
    FN_NOR  = 6'd39,
    FN_SLT  = 6'd42
  } mips_funct_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pc_src_e;

  function automatic logic [XLEN-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Control, ALU and memory-side signals of the fetch unit; the slave modport is
// the fetch unit itself, the master modport is whatever drives it (control/datapath).
interface mips_fetch_unit_if;
  import MIPS_pkg::*;

  logic              IorD;
  logic              IRWrite;
  logic              PCWrite;
  logic              Branch;
  logic [1:0]        PCSrc;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;
  logic [XLEN-1:0]   mem_rdata;

  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   instr;
  mips_op_e          op;
  mips_funct_e       funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   mdr;
  logic [XLEN-1:0]   alu_out;
  logic [XLEN-1:0]   instr_count;
  logic              pc_misalign;

  modport slave (
    input  IorD, IRWrite, PCWrite, Branch, PCSrc, alu_result, alu_zero, mem_rdata,
    output mem_addr, pc, instr, op, funct, rs, rt, rd, imm_sext, mdr, alu_out,
           instr_count, pc_misalign
  );

  modport master (
    output IorD, IRWrite, PCWrite, Branch, PCSrc, alu_result, alu_zero, mem_rdata,
    input  mem_addr, pc, instr, op, funct, rs, rt, rd, imm_sext, mdr, alu_out,
           instr_count, pc_misalign
  );

endinterface

// File: rtl/mips_pc_reg.sv
// Program counter register with its next-PC mux and a sticky flag that records
// any write of a non-word-aligned PC.
module mips_pc_reg
  import MIPS_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              Branch,
  input  logic              alu_zero,
  input  logic [1:0]        PCSrc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [XLEN-1:0]   pc,
  output logic              pc_misalign
);

  logic            pc_en;
  logic [XLEN-1:0] next_pc;

  assign pc_en = PCWrite | (Branch & alu_zero);

  // Jump targets keep the region bits of the PC, which already points past the jump.
  always_comb begin
    next_pc = pc;
    case (pc_src_e'(PCSrc))
      PCSRC_ALU:    next_pc = alu_result;
      PCSRC_ALUOUT: next_pc = alu_out;
      PCSRC_JUMP:   next_pc = {pc[XLEN-1 -: PC_REGION_W], jump_index, 2'b00};
      PCSRC_HOLD:   next_pc = pc;
      default:      next_pc = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pc_misalign <= 1'b0;
    end else if (pc_en) begin
      pc <= next_pc;
      if (next_pc[1:0] != 2'b00) begin
        pc_misalign <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage of the multicycle MIPS datapath: PC, instruction register, memory
// data register, ALU output register, fetch counter and instruction field decode.
module mips_fetch_unit
  import MIPS_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_fetch_unit_if.slave  bus
);

  logic [XLEN-1:0] pc;
  logic            pc_misalign;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] mdr_q;
  logic [XLEN-1:0] alu_out_q;
  logic [XLEN-1:0] instr_count_q;

  mips_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWrite     (bus.PCWrite),
    .Branch      (bus.Branch),
    .alu_zero    (bus.alu_zero),
    .PCSrc       (bus.PCSrc),
    .alu_result  (bus.alu_result),
    .alu_out     (alu_out_q),
    .jump_index  (instr_q[JIDX_W-1:0]),
    .pc          (pc),
    .pc_misalign (pc_misalign)
  );

  // IR and fetch counter advance together; MDR and ALUOut latch every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= '0;
      mdr_q         <= '0;
      alu_out_q     <= '0;
      instr_count_q <= '0;
    end else begin
      mdr_q     <= bus.mem_rdata;
      alu_out_q <= bus.alu_result;
      if (bus.IRWrite) begin
        instr_q       <= bus.mem_rdata;
        instr_count_q <= instr_count_q + 32'd1;
      end
    end
  end

  assign bus.mem_addr    = bus.IorD ? alu_out_q : pc;
  assign bus.pc          = pc;
  assign bus.pc_misalign = pc_misalign;
  assign bus.instr       = instr_q;
  assign bus.mdr         = mdr_q;
  assign bus.alu_out     = alu_out_q;
  assign bus.instr_count = instr_count_q;

  assign bus.op       = mips_op_e'(instr_q[OP_MSB:OP_LSB]);
  assign bus.funct    = mips_funct_e'(instr_q[FUNCT_MSB:FUNCT_LSB]);
  assign bus.rs       = instr_q[RS_MSB:RS_LSB];
  assign bus.rt       = instr_q[RT_MSB:RT_LSB];
  assign bus.rd       = instr_q[RD_MSB:RD_LSB];
  assign bus.imm_sext = sign_extend(instr_q[IMM_W-1:0]);

endmodule
